// File: rtl/prbs7_mon_pkg.sv
// Shared definitions for the PRBS7 (x^7 + x^6 + 1) receive monitor:
// state encoding, taps and the word-wide sequence predictor.
package prbs7_mon_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    localparam int TAP_A = 6;
    localparam int TAP_B = 7;
    localparam int MAX_W = 32;

    typedef struct packed {
        logic [MAX_W-1:0] word;
        logic [6:0]       hist;
    } next_t;

    // pred[6] is the most recent line bit; word bits at or above width come back zero
    function automatic next_t next_word(input logic [6:0] pred, input int width);
        logic [MAX_W+6:0] seq;
        next_t            res;
        seq      = '0;
        seq[6:0] = pred;
        for (int i = 7; i < MAX_W + 7; i++) begin
            if (i < width + 7) begin
                seq[i] = seq[i-TAP_A] ^ seq[i-TAP_B];
            end
        end
        res.word = seq[MAX_W+6:7];
        res.hist = seq[width +: 7];
        return res;
    endfunction

endpackage

// File: rtl/prbs7_rx_monitor_popcount.sv
// Combinational population count built as a recursive log-depth adder tree.
module popcount #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [OUT_W-1:0] count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_split
            localparam int LO_W = WIDTH / 2;
            localparam int HI_W = WIDTH - LO_W;

            logic [$clog2(LO_W + 1)-1:0] lo_count;
            logic [$clog2(HI_W + 1)-1:0] hi_count;

            popcount #(.WIDTH(LO_W)) u_lo (.bits(bits[LO_W-1:0]),     .count(lo_count));
            popcount #(.WIDTH(HI_W)) u_hi (.bits(bits[WIDTH-1:LO_W]), .count(hi_count));

            assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
        end
    endgenerate

endmodule

// File: rtl/prbs7_rx_monitor.sv
// PRBS7 receive monitor: self-synchronising checker with lock/loss FSM and saturating
// bit-error/word counters. Define PRBS7_RX_MONITOR_INVERT_EN to add invert_i for swapped-polarity lanes.
module prbs7_rx_monitor
    import prbs7_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             rx_clk_i,
    input  logic             rx_rst_i,
    input  logic             rx_valid_i,
    input  logic [WIDTH-1:0] rx_data_i,
    input  logic             clear_i,
`ifdef PRBS7_RX_MONITOR_INVERT_EN
    input  logic             invert_i,
`endif
    output logic             lock_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] bit_err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [1:0]       state_o
);

    localparam int PC_W   = $clog2(MAX_W + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT) + 1;
    localparam int BAD_W  = $clog2(LOSS_CNT) + 1;

    mon_state_t        state_q, state_d;
    logic [6:0]        pred_q, pred_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              err_q, err_d;
    logic              cnt_upd;
    logic [CNT_W-1:0]  bit_err_q, word_q;
    logic [CNT_W:0]    bit_err_sum, word_sum;
    logic [WIDTH-1:0]  data;
    logic [6:0]        seed;
    next_t             nxt;
    logic [MAX_W-1:0]  diff;
    logic [PC_W-1:0]   diff_bits;

`ifdef PRBS7_RX_MONITOR_INVERT_EN
    assign data = rx_data_i ^ {WIDTH{invert_i}};
`else
    assign data = rx_data_i;
`endif

    // Compare at full predictor width; the zero-padded upper bits never differ.
    assign nxt  = next_word(pred_q, WIDTH);
    assign diff = MAX_W'(data) ^ nxt.word;
    assign seed = data[WIDTH-1:WIDTH-7];

    popcount #(.WIDTH(MAX_W)) u_popcount (
        .bits  (diff),
        .count (diff_bits)
    );

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        cnt_upd = 1'b0;
        if (rx_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (seed != 7'd0) begin
                        pred_d  = seed;
                        good_d  = '0;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    pred_d = seed;
                    if (diff == '0) begin
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            good_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                        if (seed == 7'd0) begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run so a single line error cannot corrupt the following prediction.
                    pred_d  = nxt.hist;
                    cnt_upd = 1'b1;
                    if (diff != '0) begin
                        err_d = 1'b1;
                        if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
                            bad_d   = '0;
                            state_d = HUNT;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge rx_clk_i) begin
        if (rx_rst_i) begin
            state_q <= HUNT;
            pred_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    // The extra top bit of each sum is the overflow flag that pins the counter at all-ones.
    assign bit_err_sum = {1'b0, bit_err_q} + (CNT_W + 1)'(diff_bits);
    assign word_sum    = {1'b0, word_q} + (CNT_W + 1)'(1);

    always_ff @(posedge rx_clk_i) begin
        if (rx_rst_i || clear_i) begin
            bit_err_q <= '0;
            word_q    <= '0;
        end else if (cnt_upd) begin
            bit_err_q <= bit_err_sum[CNT_W] ? '1 : bit_err_sum[CNT_W-1:0];
            word_q    <= word_sum[CNT_W]    ? '1 : word_sum[CNT_W-1:0];
        end
    end

    assign lock_o        = (state_q == LOCKED);
    assign state_o       = state_q;
    assign err_pulse_o   = err_q;
    assign bit_err_cnt_o = bit_err_q;
    assign word_cnt_o    = word_q;

endmodule

// File: tb/tb_prbs7_rx_monitor.sv
// Directed bench for prbs7_rx_monitor against a bit-serial PRBS7 model; a second instance
// with 5-bit counters shows saturation on the same stimulus.
module tb_prbs7_rx_monitor;

    localparam int     LOCK_CNT = 16;
    localparam int     LOSS_CNT = 4;
    localparam longint MAX_BIG  = 64'hFFFF_FFFF;
    localparam longint MAX_SML  = 31;

    logic        rx_clk;
    logic        rx_rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        clear;

    logic        lock, err_pulse;
    logic [31:0] bit_err_cnt, word_cnt;
    logic [1:0]  state;
    logic        lock_s, err_pulse_s;
    logic [4:0]  bit_err_cnt_s, word_cnt_s;
    logic [1:0]  state_s;

    int checks   = 0;
    int failures = 0;

    int     m_state = 0;
    int     m_good  = 0;
    int     m_bad   = 0;
    bit     m_err   = 0;
    bit     m_hist[$] = '{0, 0, 0, 0, 0, 0, 0};
    longint m_bec = 0, m_wc = 0, m_bec_s = 0, m_wc_s = 0;

    bit         gen_bits[$];
    logic [7:0] w;

    prbs7_rx_monitor dut (
        .rx_clk_i      (rx_clk),
        .rx_rst_i      (rx_rst),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .clear_i       (clear),
`ifdef PRBS7_RX_MONITOR_INVERT_EN
        .invert_i      (1'b0),
`endif
        .lock_o        (lock),
        .err_pulse_o   (err_pulse),
        .bit_err_cnt_o (bit_err_cnt),
        .word_cnt_o    (word_cnt),
        .state_o       (state)
    );

    prbs7_rx_monitor #(.CNT_W(5)) dut_small (
        .rx_clk_i      (rx_clk),
        .rx_rst_i      (rx_rst),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .clear_i       (clear),
`ifdef PRBS7_RX_MONITOR_INVERT_EN
        .invert_i      (1'b0),
`endif
        .lock_o        (lock_s),
        .err_pulse_o   (err_pulse_s),
        .bit_err_cnt_o (bit_err_cnt_s),
        .word_cnt_o    (word_cnt_s),
        .state_o       (state_s)
    );

    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    // Serial PRBS7: each new line bit is the bit 6 back XOR the bit 7 back; word bit 0 goes first.
    function automatic logic [7:0] prbs_extend(input bit hist[$]);
        bit         s[$];
        logic [7:0] wd;
        s = hist;
        for (int i = 0; i < 8; i++) begin
            s.push_back(s[s.size()-6] ^ s[s.size()-7]);
            wd[i] = s[s.size()-1];
        end
        return wd;
    endfunction

    function automatic logic [7:0] next_gen_word();
        logic [7:0] wd = prbs_extend(gen_bits);
        for (int i = 0; i < 8; i++) begin
            gen_bits.push_back(wd[i]);
            void'(gen_bits.pop_front());
        end
        return wd;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input longint lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    task automatic model_seed(input logic [7:0] d);
        m_hist.delete();
        for (int i = 1; i < 8; i++) m_hist.push_back(d[i]);
    endtask

    task automatic model_step();
        logic [7:0] exp_w;
        int         nerr;
        bit         upd;
        m_err = 0;
        upd   = 0;
        nerr  = 0;
        if (rx_rst) begin
            m_state = 0; m_good = 0; m_bad = 0;
            m_hist  = '{0, 0, 0, 0, 0, 0, 0};
            m_bec = 0; m_wc = 0; m_bec_s = 0; m_wc_s = 0;
            return;
        end
        if (rx_valid) begin
            exp_w = prbs_extend(m_hist);
            nerr  = $countones(rx_data ^ exp_w);
            if (m_state == 0) begin
                if (rx_data[7:1] != 7'd0) begin
                    model_seed(rx_data);
                    m_good  = 0;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                model_seed(rx_data);
                if (nerr == 0) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_state = 2; m_good = 0; end
                end else begin
                    m_good = 0;
                    if (rx_data[7:1] == 7'd0) m_state = 0;
                end
            end else begin
                for (int i = 0; i < 8; i++) begin
                    m_hist.push_back(exp_w[i]);
                    void'(m_hist.pop_front());
                end
                upd = 1;
                if (nerr != 0) begin
                    m_err = 1;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin m_state = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (clear) begin
            m_bec = 0; m_wc = 0; m_bec_s = 0; m_wc_s = 0;
        end else if (upd) begin
            m_bec   = sat_add(m_bec, nerr, MAX_BIG);
            m_wc    = sat_add(m_wc, 1, MAX_BIG);
            m_bec_s = sat_add(m_bec_s, nerr, MAX_SML);
            m_wc_s  = sat_add(m_wc_s, 1, MAX_SML);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
        rx_valid = v;
        rx_data  = d;
        clear    = c;
        @(posedge rx_clk);
        #2;
    endtask

    always @(posedge rx_clk) begin
        model_step();
        #1;
        checkOutput("state",         64'(state),         64'(m_state));
        checkOutput("lock",          64'(lock),          64'(m_state == 2));
        checkOutput("err_pulse",     64'(err_pulse),     64'(m_err));
        checkOutput("bit_err_cnt",   64'(bit_err_cnt),   m_bec);
        checkOutput("word_cnt",      64'(word_cnt),      m_wc);
        checkOutput("state_small",   64'(state_s),       64'(m_state));
        checkOutput("err_small",     64'(err_pulse_s),   64'(m_err));
        checkOutput("bit_err_small", 64'(bit_err_cnt_s), m_bec_s);
        checkOutput("word_small",    64'(word_cnt_s),    m_wc_s);
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: run did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic relock(input string tag);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) checkOutput({tag, "_lock_after_16"}, 64'(lock), 64'd0);
            applyStimulus(1'b1, next_gen_word(), 1'b0);
        end
        checkOutput({tag, "_lock_after_17"}, 64'(lock), 64'd1);
    endtask

    initial begin
        rx_rst = 1'b1; rx_valid = 1'b0; rx_data = '0; clear = 1'b0;
        for (int i = 0; i < 7; i++) gen_bits.push_back(1'b1);
        checkOutput("model_pin_word0", 64'(prbs_extend(gen_bits)), 64'h40);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset_state", 64'(state), 64'd0);
        checkOutput("reset_lock", 64'(lock), 64'd0);
        checkOutput("reset_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("reset_word", 64'(word_cnt), 64'd0);
        rx_rst = 1'b0;

        // clean lock from seed 7'h7F
        applyStimulus(1'b1, next_gen_word(), 1'b0);
        checkOutput("state_after_seed", 64'(state), 64'd1);
        w = next_gen_word();
        checkOutput("model_pin_word1", 64'(w), 64'h30);
        applyStimulus(1'b1, w, 1'b0);
        for (int i = 2; i < 17; i++) begin
            if (i == 16) checkOutput("lock_after_16", 64'(lock), 64'd0);
            applyStimulus(1'b1, next_gen_word(), 1'b0);
        end
        checkOutput("lock_after_17", 64'(lock), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, next_gen_word(), 1'b0);
        checkOutput("clean_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("clean_words", 64'(word_cnt), 64'd3);

        // single bit 3 error
        applyStimulus(1'b1, next_gen_word() ^ 8'h08, 1'b0);
        checkOutput("bit3_pulse", 64'(err_pulse), 64'd1);
        checkOutput("bit3_count", 64'(bit_err_cnt), 64'd1);
        applyStimulus(1'b1, next_gen_word(), 1'b0);
        checkOutput("bit3_next_pulse", 64'(err_pulse), 64'd0);
        checkOutput("bit3_next_lock", 64'(lock), 64'd1);
        checkOutput("bit3_next_count", 64'(bit_err_cnt), 64'd1);

        // four inverted words drop lock
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("clear_bit_err", 64'(bit_err_cnt), 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) checkOutput("ff_lock_after_3", 64'(lock), 64'd1);
            applyStimulus(1'b1, next_gen_word() ^ 8'hFF, 1'b0);
        end
        checkOutput("ff_lock_lost", 64'(lock), 64'd0);
        checkOutput("ff_state_hunt", 64'(state), 64'd0);
        checkOutput("ff_bit_err", 64'(bit_err_cnt), 64'd32);
        checkOutput("ff_bit_err_small_sat", 64'(bit_err_cnt_s), 64'd31);
        relock("ff_relock");

        // reset mid-stream with clear, then valid toggling
        rx_rst = 1'b1;
        applyStimulus(1'b1, next_gen_word(), 1'b1);
        rx_rst = 1'b0;
        checkOutput("midrst_state", 64'(state), 64'd0);
        checkOutput("midrst_word", 64'(word_cnt), 64'd0);
        for (int i = 0; i < 34; i++) begin
            if (i % 2 == 1) applyStimulus(1'b1, next_gen_word(), 1'b0);
            else            applyStimulus(1'b0, 8'hA5, 1'b0);
            if (i == 31) checkOutput("toggle_lock_32cyc", 64'(lock), 64'd0);
            if (i == 33) checkOutput("toggle_lock_34cyc", 64'(lock), 64'd1);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) applyStimulus(1'b1, next_gen_word(), 1'b0);
            else            applyStimulus(1'b0, 8'h5A, 1'b0);
        end
        checkOutput("toggle_words", 64'(word_cnt), 64'd4);
        checkOutput("toggle_bit_err", 64'(bit_err_cnt), 64'd0);

        // all-zero stream never leaves HUNT
        rx_rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        rx_rst = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("zero_state", 64'(state), 64'd0);
        checkOutput("zero_lock", 64'(lock), 64'd0);
        checkOutput("zero_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("zero_word", 64'(word_cnt), 64'd0);

        // saturation on the small instance, then clear beats an errored word
        relock("sat_relock");
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, next_gen_word() ^ 8'h81, 1'b0);
            applyStimulus(1'b1, next_gen_word(), 1'b0);
        end
        checkOutput("sat_bit_err_big", 64'(bit_err_cnt), 64'd32);
        checkOutput("sat_bit_err_small", 64'(bit_err_cnt_s), 64'd31);
        checkOutput("sat_word_small", 64'(word_cnt_s), 64'd31);
        checkOutput("sat_lock", 64'(lock), 64'd1);
        applyStimulus(1'b1, next_gen_word() ^ 8'h81, 1'b0);
        checkOutput("sat_bit_err_big2", 64'(bit_err_cnt), 64'd34);
        checkOutput("sat_bit_err_small2", 64'(bit_err_cnt_s), 64'd31);
        applyStimulus(1'b1, next_gen_word() ^ 8'h81, 1'b1);
        checkOutput("clear_wins_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("clear_wins_word", 64'(word_cnt), 64'd0);
        checkOutput("clear_wins_lock", 64'(lock), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
